// File: rtl/moonbase_xbus_pkg.sv
// Shared definitions for the moonbase external-bus arbiter.
// Contents: FSM state enum, pin-word bit positions, wait-counter width,
// the idle pin word and a port-to-onehot helper.
package moonbase_xbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam int STROBE_BIT   = 7;
    localparam int SPACE_BIT    = 6;
    localparam int RAM_WE_N_BIT = 5;
    localparam int DEV_WE_N_BIT = 4;

    localparam int WAIT_W = 3;

    // Idle word with the default space bit (code half selected).
    localparam logic [7:0] IDLE_WORD = 8'h70;

    // Idle pin word: strobe low, both write enables inactive, data zero.
    function automatic logic [7:0] idle_word(input logic space);
        return {1'b0, space, 1'b1, 1'b1, 4'h0};
    endfunction

    // One-hot request mask for a port index.
    function automatic logic [1:0] port_bit(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/moonbase_xbus_rr2.sv
// Two-way round-robin picker.
// Ports:
//   req        - request vector, bit n = port n
//   last_grant - port index granted most recently
//   grant      - chosen port index (meaningful when valid = 1)
//   valid      - at least one request is present
module moonbase_xbus_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    // On a tie the port that was not granted last time wins.
    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/moonbase_xbus_arbiter.sv
// Arbiter for the multiplexed moonbase external bus, shared by two
// requesters. Each transaction is one address-strobe cycle followed by
// 1 + WAIT_CYCLES data cycles; read data returns with a one-cycle ack.
// Ports:
//   clk, reset_n             - clock, asynchronous active-low reset
//   ram_in, dev_in           - SRAM / device read data from the pins
//   bus_out                  - 8-bit pin word (bit 7 strobe)
//   req/we/dev/space/addr/wdata/lock _0/_1 - per-port transaction request
//   ack_0/1, rdata_0/1       - completion pulse and read data per port
// Optional build macro: MOONBASE_XBUS_LOCK_EN - a port holding lock on
// its last data cycle is re-granted if it requests in the following cycle.
module moonbase_xbus_arbiter
    import moonbase_xbus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic        IDLE_SPACE  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] ram_in,
    input  logic [1:0] dev_in,
    output logic [7:0] bus_out,
    input  logic       req_0,
    input  logic       req_1,
    input  logic       we_0,
    input  logic       we_1,
    input  logic       dev_0,
    input  logic       dev_1,
    input  logic       space_0,
    input  logic       space_1,
    input  logic [6:0] addr_0,
    input  logic [6:0] addr_1,
    input  logic [3:0] wdata_0,
    input  logic [3:0] wdata_1,
    input  logic       lock_0,
    input  logic       lock_1,
    output logic       ack_0,
    output logic       ack_1,
    output logic [3:0] rdata_0,
    output logic [3:0] rdata_1
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic              dev_q, dev_d;
    logic              space_q, space_d;
    logic [6:0]        addr_q, addr_d;
    logic [3:0]        wdata_q, wdata_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              ack_0_q, ack_0_d, ack_1_q, ack_1_d;
    logic [3:0]        rdata_0_q, rdata_0_d, rdata_1_q, rdata_1_d;

    logic [1:0] req_vec;
    logic [1:0] arb_req;
    logic       pick;
    logic       pick_valid;
    logic       last_data;
    logic       lock_take;
    logic       lock_win;
    logic       lock_port;

    assign req_vec   = {req_1, req_0};
    assign last_data = (state_q == DATA) && (wait_q == '0);

`ifdef MOONBASE_XBUS_LOCK_EN
    logic lock_win_q, lock_win_d;
    logic lock_port_q, lock_port_d;

    assign lock_take = last_data & (grant_q ? lock_1 : lock_0);
    assign lock_win  = lock_win_q;
    assign lock_port = lock_port_q;

    // The lock window is open only for the single cycle after the
    // locked port's last data cycle.
    always_comb begin
        lock_win_d  = lock_take;
        lock_port_d = lock_take ? grant_q : lock_port_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_win_q  <= 1'b0;
            lock_port_q <= 1'b0;
        end else begin
            lock_win_q  <= lock_win_d;
            lock_port_q <= lock_port_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = lock_0 ^ lock_1;
    assign lock_take   = 1'b0;
    assign lock_win    = 1'b0;
    assign lock_port   = 1'b0;
`endif

    // Requests eligible for arbitration: in IDLE all of them (or only the
    // locked port during a lock window); on the last data cycle all except
    // the port being acked, unless a lock forces a return to IDLE.
    always_comb begin
        arb_req = 2'b00;
        if (state_q == IDLE) begin
            arb_req = lock_win ? (req_vec & port_bit(lock_port)) : req_vec;
        end else if (last_data && !lock_take) begin
            arb_req = req_vec & ~port_bit(grant_q);
        end
    end

    moonbase_xbus_rr2 u_rr2 (
        .req        (arb_req),
        .last_grant (last_grant_q),
        .grant      (pick),
        .valid      (pick_valid)
    );

    // Next-state logic: grant and transaction fields are captured on
    // entry to ADDR; read data and ack are registered on the last data cycle.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        dev_d        = dev_q;
        space_d      = space_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_d       = wait_q;
        ack_0_d      = 1'b0;
        ack_1_d      = 1'b0;
        rdata_0_d    = rdata_0_q;
        rdata_1_d    = rdata_1_q;

        unique case (state_q)
            ADDR: state_d = DATA;
            DATA: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else begin
                    if (grant_q) begin
                        ack_1_d   = 1'b1;
                        rdata_1_d = we_q ? 4'h0 : (dev_q ? {2'b00, dev_in} : ram_in);
                    end else begin
                        ack_0_d   = 1'b1;
                        rdata_0_d = we_q ? 4'h0 : (dev_q ? {2'b00, dev_in} : ram_in);
                    end
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // A valid pick only occurs in IDLE or on the last data cycle.
        if (pick_valid) begin
            state_d      = ADDR;
            grant_d      = pick;
            last_grant_d = pick;
            we_d         = pick ? we_1    : we_0;
            dev_d        = pick ? dev_1   : dev_0;
            space_d      = pick ? space_1 : space_0;
            addr_d       = pick ? addr_1  : addr_0;
            wdata_d      = pick ? wdata_1 : wdata_0;
            wait_d       = WAIT_INIT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            dev_q        <= 1'b0;
            space_q      <= 1'b0;
            addr_q       <= 7'h00;
            wdata_q      <= 4'h0;
            wait_q       <= '0;
            ack_0_q      <= 1'b0;
            ack_1_q      <= 1'b0;
            rdata_0_q    <= 4'h0;
            rdata_1_q    <= 4'h0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            dev_q        <= dev_d;
            space_q      <= space_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_q       <= wait_d;
            ack_0_q      <= ack_0_d;
            ack_1_q      <= ack_1_d;
            rdata_0_q    <= rdata_0_d;
            rdata_1_q    <= rdata_1_d;
        end
    end

    // Pin word decoded from the registered state so that reset returns
    // the bus to the idle word without waiting for a clock.
    always_comb begin
        bus_out = idle_word(IDLE_SPACE);
        unique case (state_q)
            ADDR: bus_out = {1'b1, addr_q};
            DATA: begin
                bus_out[STROBE_BIT]   = 1'b0;
                bus_out[SPACE_BIT]    = space_q;
                bus_out[RAM_WE_N_BIT] = ~(we_q & ~dev_q);
                bus_out[DEV_WE_N_BIT] = ~(we_q & dev_q);
                bus_out[3:0]          = wdata_q;
            end
            default: ;
        endcase
    end

    assign ack_0   = ack_0_q;
    assign ack_1   = ack_1_q;
    assign rdata_0 = rdata_0_q;
    assign rdata_1 = rdata_1_q;

endmodule

// File: tb/tb_moonbase_xbus_arbiter.sv
// Directed bench for moonbase_xbus_arbiter: one instance at WAIT_CYCLES = 0
// and one at WAIT_CYCLES = 3 sharing clock and reset.
module tb_moonbase_xbus_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;

    // Instance A (WAIT_CYCLES = 0)
    logic [3:0] ram_in;
    logic [1:0] dev_in;
    logic [7:0] bus_out;
    logic       req_0, req_1, we_0, we_1, dev_0, dev_1, space_0, space_1;
    logic [6:0] addr_0, addr_1;
    logic [3:0] wdata_0, wdata_1;
    logic       lock_0, lock_1;
    logic       ack_0, ack_1;
    logic [3:0] rdata_0, rdata_1;

    // Instance W (WAIT_CYCLES = 3), only port 0 exercised
    logic [3:0] w_ram_in;
    logic [1:0] w_dev_in;
    logic [7:0] w_bus_out;
    logic       w_req_0, w_we_0, w_dev_0, w_space_0;
    logic [6:0] w_addr_0;
    logic [3:0] w_wdata_0;
    logic       w_ack_0, w_ack_1;
    logic [3:0] w_rdata_0, w_rdata_1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    moonbase_xbus_arbiter #(.WAIT_CYCLES(0), .IDLE_SPACE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .ram_in(ram_in), .dev_in(dev_in),
        .bus_out(bus_out),
        .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
        .dev_0(dev_0), .dev_1(dev_1), .space_0(space_0), .space_1(space_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .lock_0(lock_0), .lock_1(lock_1),
        .ack_0(ack_0), .ack_1(ack_1), .rdata_0(rdata_0), .rdata_1(rdata_1)
    );

    moonbase_xbus_arbiter #(.WAIT_CYCLES(3), .IDLE_SPACE(1'b1)) dut_w (
        .clk(clk), .reset_n(reset_n), .ram_in(w_ram_in), .dev_in(w_dev_in),
        .bus_out(w_bus_out),
        .req_0(w_req_0), .req_1(1'b0), .we_0(w_we_0), .we_1(1'b0),
        .dev_0(w_dev_0), .dev_1(1'b0), .space_0(w_space_0), .space_1(1'b0),
        .addr_0(w_addr_0), .addr_1(7'h00), .wdata_0(w_wdata_0), .wdata_1(4'h0),
        .lock_0(1'b0), .lock_1(1'b0),
        .ack_0(w_ack_0), .ack_1(w_ack_1), .rdata_0(w_rdata_0), .rdata_1(w_rdata_1)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the transaction fields of one port of instance A.
    task automatic applyStimulus(input logic port, input logic req, input logic we,
                                 input logic dev, input logic space,
                                 input logic [6:0] addr, input logic [3:0] wdata);
        if (port) begin
            req_1 = req; we_1 = we; dev_1 = dev; space_1 = space;
            addr_1 = addr; wdata_1 = wdata;
        end else begin
            req_0 = req; we_0 = we; dev_0 = dev; space_0 = space;
            addr_0 = addr; wdata_0 = wdata;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Back-to-back alternation: bus word, ack_0, ack_1 per cycle.
    logic [7:0] alt_bus  [7] = '{8'h91, 8'h30, 8'hA2, 8'h55, 8'h91, 8'h30, 8'hA2};
    logic       alt_ack0 [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       alt_ack1 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

`ifdef MOONBASE_XBUS_LOCK_EN
    logic [7:0] lock_bus [6] = '{8'h91, 8'h30, 8'hA2, 8'h55, 8'h70, 8'hA2};
`else
    logic [7:0] lock_bus [6] = '{8'h91, 8'h30, 8'hA2, 8'h55, 8'h91, 8'h30};
`endif

    initial begin
        reset_n = 1'b0;
        ram_in = 4'h0; dev_in = 2'b00; lock_0 = 1'b0; lock_1 = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'h15, 4'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 4'h0);
        w_req_0 = 1'b0; w_we_0 = 1'b0; w_dev_0 = 1'b0; w_space_0 = 1'b0;
        w_addr_0 = 7'h00; w_wdata_0 = 4'h0; w_ram_in = 4'h0; w_dev_in = 2'b00;

        // Reset held with req_0 asserted
        step();
        step();
        checkOutput("reset_bus", bus_out, 8'h70);
        checkOutput("reset_ack0", {7'b0, ack_0}, 8'h00);
        checkOutput("reset_rdata0", {4'h0, rdata_0}, 8'h00);
        checkOutput("reset_w_bus", w_bus_out, 8'h70);

        // Port 0 SRAM read
        ram_in = 4'hA;
        reset_n = 1'b1;
        step();
        checkOutput("rd0_addr", bus_out, 8'h95);
        step();
        checkOutput("rd0_data", bus_out, 8'h70);
        checkOutput("rd0_noack", {7'b0, ack_0}, 8'h00);
        step();
        checkOutput("rd0_ack", {7'b0, ack_0}, 8'h01);
        checkOutput("rd0_rdata", {4'h0, rdata_0}, 8'h0A);
        checkOutput("rd0_idle", bus_out, 8'h70);
        req_0 = 1'b0;
        step();
        checkOutput("rd0_ack_one", {7'b0, ack_0}, 8'h00);
        checkOutput("rd0_hold", {4'h0, rdata_0}, 8'h0A);

        // Port 1 device write
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'h03, 4'h6);
        step();
        checkOutput("wr1_addr", bus_out, 8'h83);
        step();
        checkOutput("wr1_data", bus_out, 8'h26);
        step();
        checkOutput("wr1_ack", {6'b0, ack_1, ack_0}, 8'h02);
        checkOutput("wr1_rdata", {4'h0, rdata_1}, 8'h00);
        checkOutput("wr1_rdata0_hold", {4'h0, rdata_0}, 8'h0A);
        req_1 = 1'b0;
        step();
        checkOutput("wr1_idle", bus_out, 8'h70);

        // Both ports requesting continuously: alternation, no idle gap
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h11, 4'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h22, 4'h5);
        for (int i = 0; i < 7; i++) begin
            step();
            checkOutput($sformatf("alt_bus_%0d", i), bus_out, alt_bus[i]);
            checkOutput($sformatf("alt_ack_%0d", i), {6'b0, ack_1, ack_0},
                        {6'b0, alt_ack1[i], alt_ack0[i]});
        end
        req_0 = 1'b0;
        step();
        checkOutput("alt_tail_data", bus_out, 8'h55);
        step();
        checkOutput("alt_tail_ack", {6'b0, ack_1, ack_0}, 8'h02);
        checkOutput("alt_tail_idle", bus_out, 8'h70);
        req_1 = 1'b0;
        step();

        // WAIT_CYCLES = 3 device read; data changes before the last cycle
        w_req_0 = 1'b1; w_dev_0 = 1'b1; w_addr_0 = 7'h05; w_dev_in = 2'b01;
        step();
        checkOutput("wait_addr", w_bus_out, 8'h85);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput($sformatf("wait_data_%0d", i), w_bus_out, 8'h30);
            checkOutput($sformatf("wait_noack_%0d", i), {7'b0, w_ack_0}, 8'h00);
        end
        w_dev_in = 2'b10;
        step();
        checkOutput("wait_ack", {7'b0, w_ack_0}, 8'h01);
        checkOutput("wait_rdata", {4'h0, w_rdata_0}, 8'h02);
        w_req_0 = 1'b0;
        step();
        checkOutput("wait_ack_one", {7'b0, w_ack_0}, 8'h00);

        // Reset during the data phase of a write
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 7'h40, 4'h9);
        step();
        checkOutput("rst_addr", bus_out, 8'hC0);
        step();
        checkOutput("rst_data", bus_out, 8'h59);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async_bus", bus_out, 8'h70);
        step();
        checkOutput("rst_noack", {6'b0, ack_1, ack_0}, 8'h00);
        dev_in = 2'b01;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'h07, 4'h0);
        reset_n = 1'b1;
        step();
        checkOutput("rst_p0_first", bus_out, 8'hC0);
        step();
        checkOutput("rst_p0_data", bus_out, 8'h59);
        step();
        checkOutput("rst_p1_addr", bus_out, 8'h87);
        checkOutput("rst_p0_ack", {6'b0, ack_1, ack_0}, 8'h01);
        checkOutput("rst_p0_rdata", {4'h0, rdata_0}, 8'h00);
        req_0 = 1'b0;
        step();
        checkOutput("rst_p1_data", bus_out, 8'h30);
        step();
        checkOutput("rst_p1_ack", {6'b0, ack_1, ack_0}, 8'h02);
        checkOutput("rst_p1_rdata", {4'h0, rdata_1}, 8'h01);
        req_1 = 1'b0;
        step();

        // lock_1 held with both ports requesting
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h11, 4'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h22, 4'h5);
        lock_1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput($sformatf("lock_bus_%0d", i), bus_out, lock_bus[i]);
        end
        req_0 = 1'b0; req_1 = 1'b0; lock_1 = 1'b0;
        reset_n = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
